// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: access size codes
// and the controller state encoding.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/lsu_ctrl_if.sv
// CPU request/response channel plus the data-memory port of the
// load/store controller. The controller is the slave of this bundle.
interface lsu_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    // CPU datapath side
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Load/store controller side
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_wr
    );

    // Data memory side
    modport mem (
        input  mem_addr, mem_wdata, mem_wr,
        output mem_rdata
    );

endinterface

// File: rtl/lsu_ctrl_lane_align.sv
// Big-endian lane handling: extracts and extends a byte/half/word from a
// memory word for loads, and merges store data into that word for
// read-modify-write stores. Byte offset 0 is the most significant byte.
module lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [4:0]  w_shift;
    logic [31:0] w_mask;
    logic [31:0] w_lane;

    // Locate the addressed lane, then extract/extend it and build the merged word.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_shift = 5'd0;
        w_mask  = 32'hFFFF_FFFF;
        w_lane  = 32'h0000_0000;
        o_load  = i_word;
        o_merge = i_wdata;
        case (i_size)
            SZ_B: begin
                // offset k sits (3-k) bytes above bit 0
                w_shift = {~i_offset, 3'b000};
                w_mask  = 32'h0000_00FF << w_shift;
                w_lane  = (i_word >> w_shift) & 32'h0000_00FF;
                o_load  = i_unsigned ? w_lane : {{24{w_lane[7]}}, w_lane[7:0]};
                o_merge = (i_word & ~w_mask) | ((i_wdata & 32'h0000_00FF) << w_shift);
            end
            SZ_H: begin
                // offset 0 -> upper half, offset 2 -> lower half
                w_shift = i_offset[1] ? 5'd0 : 5'd16;
                w_mask  = 32'h0000_FFFF << w_shift;
                w_lane  = (i_word >> w_shift) & 32'h0000_FFFF;
                o_load  = i_unsigned ? w_lane : {{16{w_lane[15]}}, w_lane[15:0]};
                o_merge = (i_word & ~w_mask) | ((i_wdata & 32'h0000_FFFF) << w_shift);
            end
            default: begin
                // whole word: load and store data pass straight through
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one request at a time, checks it,
// runs the memory read and/or write, and returns a one-cycle response.
// Sub-word stores are read-modify-write (RD then WR).
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic      clk,
    input  logic      rst,
    lsu_ctrl_if.slave bus
);

    state_t      r_state;
    state_t      w_next_state;

    // latched request fields
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_offset;
    logic [31:0] r_wdata;

    // registered outputs
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_wr;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_ready;
    logic        w_accept;
    logic        w_err;
    logic        w_word_store;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign w_ready      = (r_state == ST_IDLE) && !rst;
    assign w_accept     = bus.req_valid && w_ready;
    assign w_word_store = bus.req_we && (bus.req_size == SZ_W);

    // Reject illegal sizes, misaligned halves/words and addresses beyond the memory.
    always_comb begin
        w_err = |bus.req_addr[31:ADDR_W];
        case (bus.req_size)
            SZ_B:    ;
            SZ_H:    if (bus.req_addr[0]) w_err = 1'b1;
            SZ_W:    if (bus.req_addr[1:0] != 2'b00) w_err = 1'b1;
            default: w_err = 1'b1;
        endcase
    end

    // Lane logic always works on the word currently returned by memory.
    lane_align u_lane_align (
        .i_word     (bus.mem_rdata),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state decision.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err)             w_next_state = ST_DONE;
                    else if (w_word_store) w_next_state = ST_WR;
                    else                   w_next_state = ST_RD;
                end
            end
            ST_RD:   w_next_state = r_we ? ST_WR : ST_DONE;
            ST_WR:   w_next_state = ST_DONE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, memory port and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_size       <= SZ_B;
            r_unsigned   <= 1'b0;
            r_offset     <= 2'b00;
            r_wdata      <= 32'h0;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_wr     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            r_mem_wr     <= (w_next_state == ST_WR);
            r_resp_valid <= (w_next_state == ST_DONE);
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we       <= bus.req_we;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_offset   <= bus.req_addr[1:0];
                        r_wdata    <= bus.req_wdata;
                        r_resp_err <= w_err;
                        // a rejected request leaves the memory port untouched
                        if (!w_err) begin
                            r_mem_addr <= {bus.req_addr[31:2], 2'b00};
                            if (w_word_store) r_mem_wdata <= bus.req_wdata;
                        end
                    end
                end
                ST_RD: begin
                    if (r_we) r_mem_wdata  <= w_merge;
                    else      r_resp_rdata <= w_load;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_wr     = r_mem_wr;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a behavioural big-endian memory, a
// reference word array, and a scoreboard queue of expected responses.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n_wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    exp_t        sb_q [$];

    lsu_ctrl_if bus ();

    lsu_ctrl #(.ADDR_W(10)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: writes on the rising edge, read data refreshes on the falling edge.
    always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    always @(negedge clk) if (!bus.mem_wr) bus.mem_rdata <= mem[bus.mem_addr[9:2]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one request; stores update the reference array.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        int          k;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.n_wr  = 0;
        e.lat   = 1;
        e.waddr = {addr[31:2], 2'b00};
        e.wdata = 32'h0;
        if (sz == 2'b11 || (sz == SZ_H && addr[0]) || (sz == SZ_W && addr[1:0] != 2'b00) ||
            addr[31:10] != 22'h0) begin
            e.err = 1'b1;
            return;
        end
        w = ref_mem[addr[9:2]];
        k = int'(addr[1:0]);
        if (!we) begin
            e.lat = 2;
            case (sz)
                SZ_B: begin
                    b = w[8*(3-k) +: 8];
                    e.rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
                end
                SZ_H: begin
                    h = (k == 0) ? w[31:16] : w[15:0];
                    e.rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
                end
                default: e.rdata = w;
            endcase
        end else begin
            e.n_wr = 1;
            e.lat  = (sz == SZ_W) ? 2 : 3;
            case (sz)
                SZ_B:    w[8*(3-k) +: 8] = wdata[7:0];
                SZ_H:    if (k == 0) w[31:16] = wdata[15:0]; else w[15:0] = wdata[15:0];
                default: w = wdata;
            endcase
            ref_mem[addr[9:2]] = w;
            e.wdata = w;
        end
    endtask

    // Issue one request, then watch the DUT until its response (bounded).
    task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                          output logic [31:0] rdata_o, output logic [31:0] wdata_o);
        exp_t e;
        exp_t got_e;
        int   n_wr;
        int   n_acc;
        bit   got;
        logic [31:0] waddr;
        @(negedge clk);
        check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, " idle_quiet"}, {30'h0, bus.resp_valid, bus.mem_wr}, 32'd0);
        model(we, sz, uns, addr, wdata, e);
        sb_q.push_back(e);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.req_valid    = 1'b0;
            bus.req_we       = 1'($urandom);
            bus.req_size     = 2'($urandom);
            bus.req_unsigned = 1'($urandom);
            bus.req_addr     = $urandom;
            bus.req_wdata    = $urandom;
        end
        got = 1'b0; n_wr = 0; n_acc = 0; waddr = 32'h0;
        rdata_o = 32'h0; wdata_o = 32'h0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            if (bus.mem_wr) begin
                n_wr++;
                waddr   = bus.mem_addr;
                wdata_o = bus.mem_wdata;
            end
            if (bus.req_valid && bus.req_ready) n_acc++;
            if (bus.resp_valid) begin
                got     = 1'b1;
                rdata_o = bus.resp_rdata;
                if (sb_q.size() > 0) begin
                    got_e = sb_q.pop_front();
                    check({tag, " latency"}, 32'(c), 32'(got_e.lat));
                    check({tag, " rdata"}, bus.resp_rdata, got_e.rdata);
                    check({tag, " err"}, 32'(bus.resp_err), 32'(got_e.err));
                    check({tag, " wr_cycles"}, 32'(n_wr), 32'(got_e.n_wr));
                    if (got_e.n_wr != 0) begin
                        check({tag, " wr_addr"}, waddr, got_e.waddr);
                        check({tag, " wr_data"}, wdata_o, got_e.wdata);
                    end
                end else begin
                    check({tag, " unexpected_resp"}, 32'd1, 32'd0);
                end
            end
        end
        check({tag, " resp_seen"}, 32'(got), 32'd1);
        if (hold) begin
            check({tag, " extra_accepts"}, 32'(n_acc), 32'd0);
            bus.req_valid = 1'b0;
        end
    endtask

    logic [31:0] rd;
    logic [31:0] wd;
    int          n_wr;
    int          n_rv;

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        rst = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready", 32'(bus.req_ready), 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'h0);
        check("rst mem_wdata", bus.mem_wdata, 32'h0);
        check("rst flags", {29'h0, bus.mem_wr, bus.resp_valid, bus.resp_err}, 32'h0);
        check("rst resp_rdata", bus.resp_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // word store / load
        do_req("sw10", 1'b1, SZ_W, 1'b0, 32'h10, 32'h1234_5678, 1'b0, rd, wd);
        do_req("lw10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, rd, wd);
        check("lw10 value", rd, 32'h1234_5678);

        // byte read-modify-write and byte loads
        do_req("sb12", 1'b1, SZ_B, 1'b0, 32'h12, 32'h5A5A_5A80, 1'b0, rd, wd);
        check("sb12 merged", wd, 32'h1234_8078);
        do_req("lb12", 1'b0, SZ_B, 1'b0, 32'h12, 32'h0, 1'b0, rd, wd);
        check("lb12 value", rd, 32'hFFFF_FF80);
        do_req("lbu12", 1'b0, SZ_B, 1'b1, 32'h12, 32'h0, 1'b0, rd, wd);
        check("lbu12 value", rd, 32'h0000_0080);
        do_req("lb11", 1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 1'b0, rd, wd);
        check("lb11 value", rd, 32'h0000_0034);

        // halfword
        do_req("sh12", 1'b1, SZ_H, 1'b0, 32'h12, 32'h1111_BEEF, 1'b0, rd, wd);
        check("sh12 merged", wd, 32'h1234_BEEF);
        do_req("lh12", 1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 1'b0, rd, wd);
        check("lh12 value", rd, 32'hFFFF_BEEF);
        do_req("lhu12", 1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 1'b0, rd, wd);
        check("lhu12 value", rd, 32'h0000_BEEF);
        do_req("lh10", 1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 1'b0, rd, wd);
        check("lh10 value", rd, 32'h0000_1234);

        // error responses: no memory traffic, memory unchanged
        do_req("lw11 err", 1'b0, SZ_W, 1'b0, 32'h11, 32'h0, 1'b0, rd, wd);
        do_req("sh13 err", 1'b1, SZ_H, 1'b0, 32'h13, 32'hFFFF_FFFF, 1'b0, rd, wd);
        do_req("sz3 err", 1'b1, 2'b11, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, rd, wd);
        do_req("sw400 err", 1'b1, SZ_W, 1'b0, 32'h400, 32'hDEAD_BEEF, 1'b0, rd, wd);
        do_req("lw10 after err", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, rd, wd);
        check("lw10 after err value", rd, 32'h1234_BEEF);

        // top of memory
        do_req("sw3fc", 1'b1, SZ_W, 1'b0, 32'h3FC, 32'hCAFE_F00D, 1'b0, rd, wd);
        do_req("sb3ff", 1'b1, SZ_B, 1'b0, 32'h3FF, 32'h0000_0011, 1'b0, rd, wd);
        do_req("lw3fc", 1'b0, SZ_W, 1'b0, 32'h3FC, 32'h0, 1'b0, rd, wd);
        check("lw3fc value", rd, 32'hCAFE_F011);

        // request held high while busy: exactly one accept
        do_req("sb hold", 1'b1, SZ_B, 1'b0, 32'h13, 32'h0000_00A5, 1'b1, rd, wd);
        do_req("lw hold check", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, rd, wd);
        check("lw hold value", rd, 32'h1234_BEA5);

        // reset during RD of a byte store aborts it
        do_req("sw20", 1'b1, SZ_W, 1'b0, 32'h20, 32'h55AA_33CC, 1'b0, rd, wd);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_B;
        bus.req_addr  = 32'h21;
        bus.req_wdata = 32'h0000_00EE;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort rd mem_wr", 32'(bus.mem_wr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        n_wr = 0;
        n_rv = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) check("abort ready after rst", 32'(bus.req_ready), 32'd1);
            if (bus.mem_wr) n_wr++;
            if (bus.resp_valid) n_rv++;
        end
        check("abort no write", 32'(n_wr), 32'd0);
        check("abort no resp", 32'(n_rv), 32'd0);
        do_req("lw20", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 1'b0, rd, wd);
        check("lw20 value", rd, 32'h55AA_33CC);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
